// File: rtl/tm1638_pkg.sv
// tm1638_pkg: command bytes, FSM state encoding and key-position helpers shared by the TM1638 reader and writer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_DISP_ON    = 8'h8F;

    localparam int unsigned CMD_BITS = 8;
    localparam int unsigned KEY_BITS = 32;
    localparam int unsigned NUM_KEYS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STB_SETUP = 3'd1,
        ST_CMD       = 3'd2,
        ST_WAIT      = 3'd3,
        ST_READ      = 3'd4,
        ST_STB_END   = 3'd5
    } tm_state_e;

    // Key i lives in bit 0 (keys 0-3) or bit 4 (keys 4-7) of scan byte i%4.
    function automatic int unsigned key_map(input int unsigned i);
        return ((i % 4) * 8) + ((i / 4) * 4);
    endfunction

    // Pulls the eight meaningful bits out of the 32-bit raw scan.
    function automatic logic [7:0] decode_keys(input logic [31:0] raw);
        logic [7:0] k;
        k = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            k[3'(i)] = raw[5'(key_map(i))];
        end
        return k;
    endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// tm1638_bit_timer: HALF_CYC divider producing the serial clock level plus fall/rise/bit-end strobes.
// Latency: strobes are combinational from the counter; fall/rise flag the cycle whose end edge moves a registered CLK.
// Backpressure: none; counts only while run=1 and parks at the start of a low half when run=0.
module tm1638_bit_timer
    import tm1638_pkg::*;
#(
    parameter int unsigned HALF_CYC = 1
) (
    input  logic clk_1mhz,
    input  logic rst_n,
    input  logic run,
    output logic clk_level,
    output logic clk_fall,
    output logic clk_rise,
    output logic bit_done
);

    localparam int unsigned CW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          half_end;

    assign half_end = (cnt_q == HALF_LAST);

    // Half-period counter: reloads and flips the CLK phase at the end of every half.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and phase state.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign clk_level = phase_q;
    assign clk_fall  = run & ~phase_q & (cnt_q == '0);
    assign clk_rise  = run &  phase_q & (cnt_q == '0);
    assign bit_done  = run &  phase_q & half_end;

endmodule

// File: rtl/tm1638_key_reader.sv
// tm1638_key_reader: issues key-scan command 0x42, clocks in 32 DIO bits and decodes them to 8 keys.
// Latency: done pulses 2 + 80*HALF_CYC + TWAIT_CYC cycles after start is accepted; pad outputs are registered.
// Backpressure: start taken only in IDLE with busy low; requests while busy are dropped, never queued.
// Option: define TM1638_KEY_DEBOUNCE_EN to publish keys only when two consecutive scans decode identically.
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int unsigned HALF_CYC  = 1,
    parameter int unsigned TWAIT_CYC = 2
) (
    input  logic        clk_1mhz,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic        tm_dio_in,
    output logic [31:0] key_raw,
    output logic [7:0]  keys,
    output logic        key_change
);

    localparam int unsigned   WW        = (TWAIT_CYC > 1) ? $clog2(TWAIT_CYC) : 1;
    localparam logic [4:0]    CMD_LAST  = 5'(CMD_BITS - 1);
    localparam logic [4:0]    READ_LAST = 5'(KEY_BITS - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TWAIT_CYC - 1);

    tm_state_e     state_q, state_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]   shift_q;

    logic stb_q, stb_d;
    logic sclk_q, sclk_d;
    logic dout_q, dout_d;
    logic oe_q, oe_d;

    logic        busy_q, done_q, key_change_q;
    logic [31:0] key_raw_q;
    logic [7:0]  keys_q;
    logic [7:0]  decoded;
    logic        publish;

    logic run, clk_level, clk_fall, clk_rise, bit_done;

    assign run     = (state_q == ST_CMD) || (state_q == ST_READ);
    assign decoded = decode_keys(shift_q);

    tm1638_bit_timer #(
        .HALF_CYC (HALF_CYC)
    ) u_bit_timer (
        .clk_1mhz  (clk_1mhz),
        .rst_n     (rst_n),
        .run       (run),
        .clk_level (clk_level),
        .clk_fall  (clk_fall),
        .clk_rise  (clk_rise),
        .bit_done  (bit_done)
    );

    // Next state, bit/wait counters and the pad levels to register for the next cycle.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        stb_d      = 1'b1;
        sclk_d     = 1'b1;
        oe_d       = 1'b0;
        dout_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    state_d = ST_STB_SETUP;
                end
            end
            ST_STB_SETUP: begin
                stb_d     = 1'b0;
                oe_d      = 1'b1;
                bit_cnt_d = '0;
                state_d   = ST_CMD;
            end
            ST_CMD: begin
                stb_d  = 1'b0;
                oe_d   = 1'b1;
                sclk_d = clk_level;
                // Data only moves together with the falling CLK edge, held otherwise.
                dout_d = clk_fall ? CMD_READ_KEYS[bit_cnt_q[2:0]] : dout_q;
                if (bit_done) begin
                    if (bit_cnt_q == CMD_LAST) begin
                        bit_cnt_d  = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_WAIT: begin
                stb_d = 1'b0;
                if (wait_cnt_q == WAIT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = ST_READ;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_READ: begin
                stb_d  = 1'b0;
                sclk_d = clk_level;
                if (bit_done) begin
                    if (bit_cnt_q == READ_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STB_END;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_STB_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Registered pad outputs so STB/CLK/DIO never glitch; busy/done follow the state one cycle later.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            stb_q  <= 1'b1;
            sclk_q <= 1'b1;
            oe_q   <= 1'b0;
            dout_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            stb_q  <= stb_d;
            sclk_q <= sclk_d;
            oe_q   <= oe_d;
            dout_q <= dout_d;
            busy_q <= (state_q != ST_IDLE);
            done_q <= (state_q == ST_STB_END);
        end
    end

    // Sample DIO on the edge where the registered CLK rises; first bit ends up in shift_q[0].
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if ((state_q == ST_READ) && clk_rise) begin
            shift_q <= {tm_dio_in, shift_q[31:1]};
        end
    end

`ifdef TM1638_KEY_DEBOUNCE_EN
    logic [7:0] cand_q;

    assign publish = (decoded == cand_q);

    // Remember each completed scan so the next one can confirm it.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= '0;
        end else if (state_q == ST_STB_END) begin
            cand_q <= decoded;
        end
    end
`else
    assign publish = 1'b1;
`endif

    // Publish scan results: raw bytes every scan, keys when accepted, change pulse only on a real difference.
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            key_raw_q    <= '0;
            keys_q       <= '0;
            key_change_q <= 1'b0;
        end else begin
            key_change_q <= 1'b0;
            if (state_q == ST_STB_END) begin
                key_raw_q <= shift_q;
                if (publish) begin
                    keys_q       <= decoded;
                    key_change_q <= (decoded != keys_q);
                end
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign tm_stb     = stb_q;
    assign tm_clk     = sclk_q;
    assign tm_dio_out = dout_q;
    assign tm_dio_oe  = oe_q;
    assign key_raw    = key_raw_q;
    assign keys       = keys_q;
    assign key_change = key_change_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb_tm1638_key_reader: bench for the TM1638 key reader with a TM1638 DIO responder and a result scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_tm1638_key_reader;

    typedef struct packed {
        logic [31:0] raw;
        logic [7:0]  keys;
        logic        chg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic        tm_dio_in = 1'b1;

    logic        busy, done, tm_stb, tm_clk, tm_dio_out, tm_dio_oe, key_change;
    logic [31:0] key_raw;
    logic [7:0]  keys;

    logic        busy3, done3, stb3, clk3, dout3, oe3, chg3;
    logic [31:0] raw3;
    logic [7:0]  keys3;

    int tests = 0;
    int fails = 0;

    exp_t        exp_q[$];
    logic        cmd_q[$];
    logic [31:0] model_raw = '0;
    logic [7:0]  m_keys = '0;
    logic [7:0]  m_cand = '0;

    logic prev_clk = 1'b1;
    logic prev_dio = 1'b1;
    logic prev_oe  = 1'b0;
    int   bit_idx = 0;
    int   rd_rise = 0;
    int   done_cnt = 0;
    int   dio_glitch = 0;

    int          lat;
    bit          timed_out;
    int          busy_gap;
    logic [31:0] obs_raw;
    logic [7:0]  obs_keys;
    logic        obs_chg, obs_busy_done, obs_busy_after;

    tm1638_key_reader dut (
        .clk_1mhz   (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .tm_stb     (tm_stb),
        .tm_clk     (tm_clk),
        .tm_dio_out (tm_dio_out),
        .tm_dio_oe  (tm_dio_oe),
        .tm_dio_in  (tm_dio_in),
        .key_raw    (key_raw),
        .keys       (keys),
        .key_change (key_change)
    );

    tm1638_key_reader #(.HALF_CYC(3), .TWAIT_CYC(2)) dut3 (
        .clk_1mhz   (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .busy       (busy3),
        .done       (done3),
        .tm_stb     (stb3),
        .tm_clk     (clk3),
        .tm_dio_out (dout3),
        .tm_dio_oe  (oe3),
        .tm_dio_in  (1'b1),
        .key_raw    (raw3),
        .keys       (keys3),
        .key_change (chg3)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] bench_decode(input logic [31:0] r);
        logic [7:0] k;
        k[3:0] = {r[24], r[16], r[8], r[0]};
        k[7:4] = {r[28], r[20], r[12], r[4]};
        return k;
    endfunction

    // TM1638 responder and bus monitor, sampled on the falling system clock.
    always @(negedge clk) begin
        if (tm_stb) begin
            bit_idx   = 0;
            rd_rise   = 0;
            tm_dio_in = 1'b1;
        end else begin
            if (prev_clk && !tm_clk && !tm_dio_oe && bit_idx < 32) begin
                tm_dio_in = model_raw[bit_idx[4:0]];
                bit_idx++;
            end
            if (!prev_clk && tm_clk && !tm_dio_oe) rd_rise++;
            if (!prev_clk && tm_clk && tm_dio_oe) cmd_q.push_back(tm_dio_out);
        end
        if (tm_dio_oe && prev_oe && (tm_dio_out != prev_dio) && !(prev_clk && !tm_clk)) dio_glitch++;
        if (done) done_cnt++;
        prev_clk = tm_clk;
        prev_dio = tm_dio_out;
        prev_oe  = tm_dio_oe;
    end

    // Drive one scan, push its expected result, and wait (bounded) for done.
    task automatic run_scan(input logic [31:0] raw, input bit hold);
        exp_t       e;
        logic [7:0] dec;
        dec = bench_decode(raw);
`ifdef TM1638_KEY_DEBOUNCE_EN
        if (dec == m_cand) begin
            e.chg  = (dec != m_keys);
            m_keys = dec;
        end else begin
            e.chg = 1'b0;
        end
        m_cand = dec;
`else
        e.chg  = (dec != m_keys);
        m_keys = dec;
`endif
        e.raw  = raw;
        e.keys = m_keys;
        exp_q.push_back(e);
        busy_gap = 0;
        @(negedge clk);
        model_raw = raw;
        start     = 1'b1;
        @(posedge clk);
        lat       = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                timed_out     = 1'b0;
                obs_raw       = key_raw;
                obs_keys      = keys;
                obs_chg       = key_change;
                obs_busy_done = busy;
                break;
            end
            if (!busy) busy_gap++;
        end
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            obs_busy_after = busy;
            start = 1'b0;
        end else begin
            @(negedge clk);
            obs_busy_after = busy;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        tests++; if (tm_stb !== 1'b1) begin fails++; $display("FAIL reset_stb: got %b expected 1", tm_stb); end
        tests++; if (tm_clk !== 1'b1) begin fails++; $display("FAIL reset_clk: got %b expected 1", tm_clk); end
        tests++; if (tm_dio_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b expected 0", tm_dio_oe); end
        tests++; if (tm_dio_out !== 1'b1) begin fails++; $display("FAIL reset_dout: got %b expected 1", tm_dio_out); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        tests++; if (keys !== 8'h00 || key_raw !== 32'h0 || key_change !== 1'b0) begin
            fails++; $display("FAIL reset_keys: got keys=%h raw=%h chg=%b expected 0/0/0", keys, key_raw, key_change);
        end
    endtask

    task automatic test_first_scan();
        exp_t       e;
        int         base, g0;
        logic [7:0] cmd_obs;
        base = cmd_q.size();
        g0   = dio_glitch;
        run_scan(32'h0010_0001, 1'b0);
        tests++; if (timed_out || lat != 84) begin fails++; $display("FAIL first_latency: got %0d (timeout=%0b) expected 84", lat, timed_out); end
        tests++; if (cmd_q.size() - base != 8) begin fails++; $display("FAIL cmd_bit_count: got %0d expected 8", cmd_q.size() - base); end
        cmd_obs = '0;
        for (int i = 0; i < 8 && base + i < cmd_q.size(); i++) cmd_obs[i] = cmd_q[base + i];
        tests++; if (cmd_obs !== 8'h42) begin fails++; $display("FAIL cmd_bits: got %h expected 42", cmd_obs); end
        tests++; if (dio_glitch != g0) begin fails++; $display("FAIL dio_edge: got %0d changes off CLK fall expected 0", dio_glitch - g0); end
        tests++; if (busy_gap != 0 || obs_busy_done !== 1'b1) begin
            fails++; $display("FAIL busy_span: got gaps=%0d busy_at_done=%b expected 0/1", busy_gap, obs_busy_done);
        end
        tests++; if (obs_busy_after !== 1'b0) begin fails++; $display("FAIL busy_after_done: got %b expected 0", obs_busy_after); end
        if (exp_q.size() == 0) begin
            tests++; fails++; $display("FAIL first_scoreboard: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            tests++; if (obs_raw !== e.raw) begin fails++; $display("FAIL first_raw: got %h expected %h", obs_raw, e.raw); end
            tests++; if (obs_keys !== e.keys || obs_chg !== e.chg) begin
                fails++; $display("FAIL first_keys: got %h/%b expected %h/%b", obs_keys, obs_chg, e.keys, e.chg);
            end
        end
    endtask

    task automatic test_repeat_hold();
        exp_t e;
        int   d0;
        @(negedge clk); #1;
        d0 = done_cnt;
        run_scan(32'h0010_0001, 1'b1);
        tests++; if (timed_out) begin fails++; $display("FAIL hold_done: got timeout expected done"); end
        e = exp_q.pop_front();
        tests++; if (obs_raw !== e.raw || obs_keys !== e.keys || obs_chg !== e.chg) begin
            fails++; $display("FAIL repeat_scan: got %h/%h/%b expected %h/%h/%b", obs_raw, obs_keys, obs_chg, e.raw, e.keys, e.chg);
        end
        repeat (150) @(negedge clk);
        #1;
        tests++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            fails++; $display("FAIL hold_single_scan: got %0d scans busy=%b expected 1 scan busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_patterns();
        logic [31:0] pats [5];
        exp_t        e;
        pats = '{32'h1111_1111, 32'hEEEE_EEEE, 32'h1000_0001, 32'h1000_0001, 32'h0000_0010};
        for (int p = 0; p < 5; p++) begin
            run_scan(pats[p], 1'b0);
            e = exp_q.pop_front();
            tests++; if (timed_out || obs_raw !== e.raw || obs_keys !== e.keys || obs_chg !== e.chg) begin
                fails++; $display("FAIL pattern_%0d: got %h/%h/%b expected %h/%h/%b", p, obs_raw, obs_keys, obs_chg, e.raw, e.keys, e.chg);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        bit   reached;
        @(negedge clk);
        model_raw = 32'hA5A5_5A5A;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (rd_rise >= 12) begin reached = 1'b1; break; end
        end
        tests++; if (!reached) begin fails++; $display("FAIL reach_read_bit12: got %0d bits expected 12", rd_rise); end
        rst_n = 1'b0;
        #1;
        tests++; if (tm_stb !== 1'b1 || tm_clk !== 1'b1 || tm_dio_oe !== 1'b0 || tm_dio_out !== 1'b1) begin
            fails++; $display("FAIL midreset_pads: got stb=%b clk=%b oe=%b dout=%b expected 1/1/0/1", tm_stb, tm_clk, tm_dio_oe, tm_dio_out);
        end
        tests++; if (busy !== 1'b0 || done !== 1'b0 || key_raw !== 32'h0 || keys !== 8'h0 || key_change !== 1'b0) begin
            fails++; $display("FAIL midreset_state: got busy=%b done=%b raw=%h keys=%h chg=%b expected all 0", busy, done, key_raw, keys, key_change);
        end
        m_keys = '0;
        m_cand = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_scan(32'h0001_0100, 1'b0);
        e = exp_q.pop_front();
        tests++; if (timed_out || lat != 84 || obs_raw !== e.raw || obs_keys !== e.keys || obs_chg !== e.chg) begin
            fails++; $display("FAIL rescan: got lat=%0d %h/%h/%b expected lat=84 %h/%h/%b", lat, obs_raw, obs_keys, obs_chg, e.raw, e.keys, e.chg);
        end
    endtask

`ifdef TM1638_KEY_DEBOUNCE_EN
    task automatic test_debounce();
        exp_t e;
        run_scan(32'h0000_0001, 1'b0);
        e = exp_q.pop_front();
        tests++; if (obs_keys !== 8'h00 || obs_keys !== e.keys || obs_raw !== 32'h0000_0001) begin
            fails++; $display("FAIL debounce_first: got keys=%h raw=%h expected keys=00 raw=00000001", obs_keys, obs_raw);
        end
        run_scan(32'h0000_0001, 1'b0);
        e = exp_q.pop_front();
        tests++; if (obs_keys !== 8'h01 || obs_chg !== 1'b1 || obs_chg !== e.chg) begin
            fails++; $display("FAIL debounce_second: got keys=%h chg=%b expected keys=01 chg=1", obs_keys, obs_chg);
        end
    endtask
`endif

    task automatic test_slow_half_cyc();
        int l3;
        bit to3;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        l3  = 0;
        to3 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            l3++;
            @(negedge clk);
            start3 = 1'b0;
            if (done3) begin to3 = 1'b0; break; end
        end
        tests++; if (to3 || l3 != 244) begin fails++; $display("FAIL slow_latency: got %0d (timeout=%0b) expected 244", l3, to3); end
        tests++; if (raw3 !== 32'hFFFF_FFFF) begin fails++; $display("FAIL slow_raw: got %h expected ffffffff", raw3); end
`ifdef TM1638_KEY_DEBOUNCE_EN
        tests++; if (keys3 !== 8'h00 || chg3 !== 1'b0) begin fails++; $display("FAIL slow_keys: got %h/%b expected 00/0", keys3, chg3); end
`else
        tests++; if (keys3 !== 8'hFF || chg3 !== 1'b1) begin fails++; $display("FAIL slow_keys: got %h/%b expected ff/1", keys3, chg3); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_repeat_hold();
        test_patterns();
        test_reset_mid_scan();
`ifdef TM1638_KEY_DEBOUNCE_EN
        test_debounce();
`endif
        test_slow_half_cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
